// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters.
// A granted requester keeps the transmitter until its last byte; host pause holds at byte boundaries.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  input  logic                 pause_i,
  output logic                 tx_write_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic                 active_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic             locked;
  logic [CNT_W-1:0] idle_cnt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_valid;
  logic             owner_last;
  logic [7:0]       owner_data;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Searching downward leaves the first valid requester at or after rr_ptr as the winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  assign owner_valid = req_valid_i[owner];
  assign owner_last  = req_last_i[owner];
  assign owner_data  = req_data_i[8*owner +: 8];
  assign active_o    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_o     <= '0;
      req_ready_o <= '0;
      tx_write_o  <= 1'b0;
      tx_data_o   <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      // NOTE: non-blocking defaults make the write strobe and ready one-cycle pulses.
      tx_write_o  <= 1'b0;
      req_ready_o <= '0;
      case (state)
        IDLE: begin
          if (!pause_i) begin
            if (locked) begin
              if (owner_valid) begin
                if (!tx_busy_i) begin
                  state       <= ISSUE;
                  tx_write_o  <= 1'b1;
                  tx_data_o   <= owner_data;
                  req_ready_o <= onehot(owner);
                end
              end else if (LOCK_TIMEOUT != 0) begin
                // Owner went quiet mid-packet: release after the idle budget runs out.
                if (idle_cnt >= CNT_LIMIT) begin
                  locked   <= 1'b0;
                  grant_o  <= '0;
                  rr_ptr   <= wrap_add(owner, 1);
                  idle_cnt <= '0;
                end else begin
                  idle_cnt <= idle_cnt + 1'b1;
                end
              end
            end else if (pick_found && !tx_busy_i) begin
              owner       <= pick_idx;
              grant_o     <= onehot(pick_idx);
              state       <= ISSUE;
              tx_write_o  <= 1'b1;
              tx_data_o   <= req_data_i[8*pick_idx +: 8];
              req_ready_o <= onehot(pick_idx);
            end
          end
        end
        ISSUE: begin
          locked   <= !owner_last;
          idle_cnt <= '0;
          if (owner_last) rr_ptr <= wrap_add(owner, 1);
          state <= SETTLE;
        end
        // uart_tx raises busy one cycle after the strobe, so busy is not trusted here.
        SETTLE: state <= DRAIN;
        DRAIN: begin
          if (!tx_busy_i) begin
            state <= IDLE;
            if (!locked) grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model and per-requester byte FIFOs.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 16;
  localparam int BUSY_CYC = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 pause = 1'b0;
  logic                 tx_write_o;
  logic [7:0]           tx_data_o;
  logic                 tx_busy = 1'b0;
  logic                 active_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] fifo [NUM_REQ][8];
  int head [NUM_REQ];
  int tail [NUM_REQ];
  int bcnt = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .pause_i     (pause),
    .tx_write_o  (tx_write_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy),
    .active_o    (active_o)
  );

  always #5 clock = ~clock;

  // uart_tx stand-in: busy rises the cycle after the strobe and lasts BUSY_CYC cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_write_o) begin
      tx_busy <= 1'b1;
      bcnt    <= BUSY_CYC;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = (head[i] != tail[i]);
      req_data[8*i +: 8]  = fifo[i][head[i] % 8][7:0];
      req_last[i]         = fifo[i][head[i] % 8][8];
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    fifo[i][tail[i] % 8] = {l, d};
    tail[i]++;
    drive();
  endtask

  task automatic pop(input int i);
    head[i]++;
    drive();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    pause   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int j = 0; j < 8; j++) fifo[i][j] = '0;
    end
    drive();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Wait for the next strobe, check it belongs to requester i with byte d, then retire that byte.
  task automatic serve(input string tag, input int i, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (tx_write_o !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check({tag, " write"}, 32'(tx_write_o), 32'd1);
    check({tag, " data"},  32'(tx_data_o), 32'(d));
    check({tag, " ready"}, 32'(req_ready), 32'(1 << i));
    check({tag, " grant"}, 32'(grant), 32'(1 << i));
    @(posedge clock);
    #1;
    pop(i);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (active_o !== 1'b0 && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("reach idle", 32'(active_o), 32'd0);
  endtask

  initial begin
    int n;
    int writes;

    apply_reset();
    check("reset grant",  32'(grant), 32'd0);
    check("reset ready",  32'(req_ready), 32'd0);
    check("reset write",  32'(tx_write_o), 32'd0);
    check("reset data",   32'(tx_data_o), 32'd0);
    check("reset active", 32'(active_o), 32'd0);

    // Single byte: strobe exactly one cycle after valid is sampled.
    push(0, 8'h41, 1'b1);
    @(negedge clock);
    check("t1 write", 32'(tx_write_o), 32'd1);
    check("t1 data",  32'(tx_data_o), 32'h41);
    check("t1 ready", 32'(req_ready), 32'b0001);
    check("t1 grant", 32'(grant), 32'b0001);
    @(posedge clock);
    #1;
    pop(0);
    check("t1 ready pulse", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("t1 grant in settle", 32'(grant), 32'b0001);
    wait_idle();
    check("t1 grant released", 32'(grant), 32'd0);

    // Round robin over single-byte packets.
    apply_reset();
    push(0, 8'h10, 1'b1);
    push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    serve("t2 r0", 0, 8'h10);
    serve("t2 r1", 1, 8'h11);
    serve("t2 r2", 2, 8'h12);
    serve("t2 r3", 3, 8'h13);
    serve("t2 r0b", 0, 8'h14);

    // Packet lock: req1's three bytes go out before the waiting req2.
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    push(2, 8'hB1, 1'b1);
    serve("t3 a1", 1, 8'hA1);
    serve("t3 a2", 1, 8'hA2);
    serve("t3 a3", 1, 8'hA3);
    serve("t3 b1", 2, 8'hB1);

    // Lock timeout: req0 goes quiet mid-packet, req3 waits.
    apply_reset();
    push(0, 8'h55, 1'b0);
    push(3, 8'h33, 1'b1);
    serve("t4 r0", 0, 8'h55);
    @(negedge clock);
    wait_idle();
    n = 0;
    while (grant === 4'b0001 && n < 40) begin
      check("t4 no write while locked", 32'(tx_write_o), 32'd0);
      n++;
      @(negedge clock);
    end
    check("t4 idle cycles before release", 32'(n), 32'(TIMEOUT));
    check("t4 grant released", 32'(grant), 32'd0);
    serve("t4 r3", 3, 8'h33);

    // Pause during DRAIN: byte completes, grant and lock held, no timeout while paused.
    apply_reset();
    push(1, 8'hC1, 1'b0);
    serve("t5 c1", 1, 8'hC1);
    @(posedge clock);
    #1;
    check("t5 in drain", 32'(active_o), 32'd1);
    pause = 1'b1;
    push(3, 8'hC3, 1'b1);
    writes = 0;
    repeat (30) begin
      @(negedge clock);
      if (tx_write_o) writes++;
    end
    check("t5 writes while paused", 32'(writes), 32'd0);
    check("t5 idle while paused", 32'(active_o), 32'd0);
    check("t5 grant held", 32'(grant), 32'b0010);
    pause = 1'b0;
    push(1, 8'hC2, 1'b1);
    serve("t5 c2", 1, 8'hC2);
    serve("t5 c3", 3, 8'hC3);

    // Reset mid-DRAIN clears everything at once; pending req2 served afterwards.
    apply_reset();
    push(1, 8'h61, 1'b0);
    serve("t6 r1", 1, 8'h61);
    push(2, 8'h62, 1'b1);
    @(posedge clock);
    #1;
    check("t6 in drain", 32'(active_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6 rst grant",  32'(grant), 32'd0);
    check("t6 rst ready",  32'(req_ready), 32'd0);
    check("t6 rst write",  32'(tx_write_o), 32'd0);
    check("t6 rst data",   32'(tx_data_o), 32'd0);
    check("t6 rst active", 32'(active_o), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t6 write", 32'(tx_write_o), 32'd1);
    check("t6 data",  32'(tx_data_o), 32'h62);
    check("t6 ready", 32'(req_ready), 32'b0100);
    check("t6 grant", 32'(grant), 32'b0100);
    @(posedge clock);
    #1;
    pop(2);
    wait_idle();
    check("t6 grant released", 32'(grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
